// File: rtl/clk_div_bank.sv
// clk_div_bank -- a bank of independent programmable clock dividers.
//
// Each channel produces a registered divided clock of period P and high time
// H (both in clk cycles), plus a one-cycle tick at every rising edge of that
// divided clock. Period/high pairs are written through a valid/ready
// configuration port. Writes to a running channel are staged in a shadow pair
// and applied only at the period boundary, so a period is never truncated.
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      synchronous active-low reset
//   cfg_valid  configuration write request
//   cfg_ready  write accepted when high together with cfg_valid
//   cfg_ch     target channel of the write
//   cfg_div    requested period P
//   cfg_high   requested high time H
//   cfg_err    one-cycle pulse after an accepted-but-illegal write
//   en_req     per-channel run request (level)
//   en_ack     per-channel running indication
//   clk_out    per-channel divided clock (registered)
//   tick       per-channel pulse coincident with each clk_out rising edge
//
// Handshake: a write transfers on a rising clk edge where cfg_valid and
// cfg_ready are both high. cfg_ready depends only on cfg_ch (low while the
// addressed channel still holds an unapplied shadow write); cfg_valid may be
// raised without waiting for cfg_ready and must hold its payload until the
// transfer edge.

module clk_div_bank #(
  parameter int NUM_CH   = 4,
  parameter int DIV_W    = 8,
  parameter int DEF_DIV  = 2,
  parameter int DEF_HIGH = 1,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_high,
  output logic              cfg_err,
  input  logic [NUM_CH-1:0] en_req,
  output logic [NUM_CH-1:0] en_ack,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } state_e;

  logic [NUM_CH-1:0] pend_w;
  logic              ch_in_range;
  logic              cfg_legal;
  logic              cfg_accept;
  logic              sel_pend;
  logic              cfg_err_q;

  assign ch_in_range = int'(cfg_ch) < NUM_CH;
  assign cfg_legal   = (cfg_div >= DIV_W'(2)) && (cfg_high != '0) &&
                       (cfg_high < cfg_div) && ch_in_range;

  // An out-of-range channel matches no entry, so cfg_ready stays high and the
  // write is accepted only to be rejected with cfg_err.
  always_comb begin
    sel_pend = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(cfg_ch) == i) sel_pend = pend_w[i];
    end
  end

  assign cfg_ready  = ~sel_pend;
  assign cfg_accept = cfg_valid & cfg_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) cfg_err_q <= 1'b0;
    else        cfg_err_q <= cfg_accept & ~cfg_legal;
  end

  assign cfg_err = cfg_err_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] act_p_q, act_p_d, act_h_q, act_h_d;
    logic [DIV_W-1:0] sh_p_q, sh_p_d, sh_h_q, sh_h_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             wr;
    logic             boundary;

    assign wr       = cfg_accept && cfg_legal && (int'(cfg_ch) == i);
    assign boundary = (state_q != S_IDLE) && (cnt_q == act_p_q - DIV_W'(1));

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      act_p_d = act_p_q;
      act_h_d = act_h_q;
      sh_p_d  = sh_p_q;
      sh_h_d  = sh_h_q;
      pend_d  = pend_q;

      if (state_q == S_IDLE) begin
        // A write that landed on the final boundary of a stopping channel is
        // still in the shadow; fold it in now that no period is running.
        if (pend_q) begin
          act_p_d = sh_p_q;
          act_h_d = sh_h_q;
          pend_d  = 1'b0;
        end
        if (wr) begin
          act_p_d = cfg_div;
          act_h_d = cfg_high;
          sh_p_d  = cfg_div;
          sh_h_d  = cfg_high;
        end
        if (en_req[i]) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end else begin
        if (boundary) begin
          cnt_d = '0;
          if (pend_q) begin
            act_p_d = sh_p_q;
            act_h_d = sh_h_q;
            pend_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
        // Applied after the boundary copy: a write on the boundary cycle
        // waits for the following boundary.
        if (wr) begin
          sh_p_d = cfg_div;
          sh_h_d = cfg_high;
          pend_d = 1'b1;
        end
        if (en_req[i])     state_d = S_RUN;
        else if (boundary) state_d = S_IDLE;
        else               state_d = S_STOP;
      end

      // Outputs are registered from the next-state counter so that clk_out
      // and tick line up with the cycle in which cnt holds that value.
      clk_d  = (state_d != S_IDLE) && (cnt_d < act_h_d);
      tick_d = (state_d != S_IDLE) && (cnt_d == '0);
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        act_p_q <= DIV_W'(DEF_DIV);
        act_h_q <= DIV_W'(DEF_HIGH);
        sh_p_q  <= DIV_W'(DEF_DIV);
        sh_h_q  <= DIV_W'(DEF_HIGH);
        pend_q  <= 1'b0;
        clk_q   <= 1'b0;
        tick_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        act_p_q <= act_p_d;
        act_h_q <= act_h_d;
        sh_p_q  <= sh_p_d;
        sh_h_q  <= sh_h_d;
        pend_q  <= pend_d;
        clk_q   <= clk_d;
        tick_q  <= tick_d;
      end
    end

    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;
    assign en_ack[i]  = (state_q != S_IDLE);
    assign pend_w[i]  = pend_q;
  end

endmodule
